// File: rtl/max_min_frame_ctrl.sv
// Frame sequencer: accepts FRAME_LEN samples over valid/ready and publishes frame max/min.
// Optional macro MAXMIN_RANGE_EN adds a registered range_out = max_out - min_out.
module max_min_frame_ctrl #(
   parameter int WIDTH     = 4,
   parameter int FRAME_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] max_out,
`ifdef MAXMIN_RANGE_EN
   output logic [WIDTH-1:0] min_out,
   output logic [WIDTH-1:0] range_out
`else
   output logic [WIDTH-1:0] min_out
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [7:0]       count;
   logic [WIDTH-1:0] max_r;
   logic [WIDTH-1:0] min_r;
   logic [WIDTH-1:0] max_next;
   logic [WIDTH-1:0] min_next;
   logic             accept;
   logic             first;
   logic             last;
   logic             finish;

   assign accept = (state == ACCUM) && in_valid && in_ready;
   assign first  = (count == 8'd0);
   assign last   = (count == 8'(FRAME_LEN - 1));
   assign finish = accept && last && !abort;
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // abort takes priority over the closing handshake of a frame
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ACCUM;
         ACCUM: begin
            if (abort)       next_state = IDLE;
            else if (finish) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_ready <= 1'b0;
      else     in_ready <= (next_state == ACCUM);
   end

   // The first sample of a frame seeds both running registers
   always_comb begin
      max_next = max_r;
      min_next = min_r;
      if (first) begin
         max_next = in_data;
         min_next = in_data;
      end else begin
         if (in_data > max_r) max_next = in_data;
         if (in_data < min_r) min_next = in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 8'd0;
         max_r <= '0;
         min_r <= '0;
      end else if (state == IDLE && start) begin
         count <= 8'd0;
      end else if (accept) begin
         count <= count + 8'd1;
         max_r <= max_next;
         min_r <= min_next;
      end
   end

   // Results load on the edge that accepts the last sample, so they are visible with done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_out <= '0;
         min_out <= '0;
      end else if (finish) begin
         max_out <= max_next;
         min_out <= min_next;
      end
   end

`ifdef MAXMIN_RANGE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         range_out <= '0;
      else if (finish) range_out <= max_next - min_next;
   end
`endif

endmodule

// File: tb/tb_max_min_frame_ctrl.sv
// Directed self-checking bench for max_min_frame_ctrl (default FRAME_LEN=8, WIDTH=4).
// Range output is checked too when MAXMIN_RANGE_EN is defined.
module tb_max_min_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       busy;
   logic       done;
   logic [3:0] max_out;
   logic [3:0] min_out;
`ifdef MAXMIN_RANGE_EN
   logic [3:0] range_out;
`endif

   int vectors    = 0;
   int miscompares = 0;

   max_min_frame_ctrl #(.WIDTH(4), .FRAME_LEN(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .max_out  (max_out),
`ifdef MAXMIN_RANGE_EN
      .min_out  (min_out),
      .range_out(range_out)
`else
      .min_out  (min_out)
`endif
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, then settle 1 time unit past the rising edge
   task automatic applyStimulus(input logic v, input logic [3:0] d,
                                input logic s, input logic a);
      in_valid = v;
      in_data  = d;
      start    = s;
      abort    = a;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkRange(input string tag, input logic [3:0] exp);
`ifdef MAXMIN_RANGE_EN
      checkOutput(tag, {28'd0, range_out}, {28'd0, exp});
`endif
   endtask

   initial begin
      logic [3:0] t2 [8];
      logic [3:0] t6 [8];
      t2 = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd7, 4'd0, 4'd12, 4'd5};
      t6 = '{4'd2, 4'd2, 4'd8, 4'd8, 4'd4, 4'd4, 4'd6, 4'd6};

      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 4'd0;
      #12;
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_max", max_out, 0);
      checkOutput("rst_min", min_out, 0);
      checkRange("rst_range", 4'd0);
      rst = 1'b0;
      applyStimulus(0, 4'd0, 0, 0);
      checkOutput("idle_in_ready", in_ready, 0);

      // Back-to-back frame
      applyStimulus(0, 4'd0, 1, 0);
      checkOutput("t2_busy", busy, 1);
      checkOutput("t2_in_ready", in_ready, 1);
      for (int i = 0; i < 7; i++) applyStimulus(1, t2[i], 0, 0);
      checkOutput("t2_done_early", done, 0);
      applyStimulus(1, t2[7], 0, 0);
      checkOutput("t2_done", done, 1);
      checkOutput("t2_max", max_out, 15);
      checkOutput("t2_min", min_out, 0);
      checkOutput("t2_in_ready_drop", in_ready, 0);
      checkRange("t2_range", 4'd15);
      applyStimulus(1, 4'd2, 1'b1, 0);
      checkOutput("t2_done_pulse", done, 0);
      checkOutput("t2_idle_busy", busy, 0);
      checkOutput("t2_max_hold", max_out, 15);

      // All-equal frame
      applyStimulus(0, 4'd0, 1, 0);
      for (int i = 0; i < 8; i++) applyStimulus(1, 4'hA, 0, 0);
      checkOutput("t3_done", done, 1);
      checkOutput("t3_max", max_out, 4'hA);
      checkOutput("t3_min", min_out, 4'hA);
      checkRange("t3_range", 4'd0);
      applyStimulus(0, 4'd0, 0, 0);

      // Gapped valid, plus valid asserted while idle
      applyStimulus(1, 4'd14, 0, 0);
      applyStimulus(1, 4'd14, 0, 0);
      applyStimulus(1, 4'd14, 1, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 4'd6, 0, 0);
         if (i == 7) checkOutput("t4_done_early", done, 0);
         applyStimulus(1, t2[i], 0, 0);
      end
      checkOutput("t4_done", done, 1);
      checkOutput("t4_max", max_out, 15);
      checkOutput("t4_min", min_out, 0);
      applyStimulus(0, 4'd0, 0, 0);

      // Abort after three samples; abort in IDLE is ignored
      applyStimulus(0, 4'd0, 0, 1);
      checkOutput("t5_idle_abort", busy, 0);
      applyStimulus(0, 4'd0, 1, 0);
      applyStimulus(1, 4'd2, 0, 0);
      applyStimulus(1, 4'd3, 0, 0);
      applyStimulus(1, 4'd4, 0, 0);
      applyStimulus(0, 4'd0, 0, 1);
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_done", done, 0);
      checkOutput("t5_in_ready", in_ready, 0);
      checkOutput("t5_max", max_out, 15);
      checkOutput("t5_min", min_out, 0);
      applyStimulus(0, 4'd0, 0, 0);
      checkOutput("t5_done_later", done, 0);

      // Abort on the final handshake; start+abort together in IDLE starts a frame
      applyStimulus(0, 4'd0, 1, 1);
      checkOutput("t5b_start_abort", busy, 1);
      for (int i = 0; i < 7; i++) applyStimulus(1, 4'd5, 0, 0);
      applyStimulus(1, 4'd5, 0, 1);
      checkOutput("t5b_done", done, 0);
      checkOutput("t5b_busy", busy, 0);
      checkOutput("t5b_max", max_out, 15);
      checkOutput("t5b_min", min_out, 0);
      applyStimulus(0, 4'd0, 0, 0);
      checkOutput("t5b_done_later", done, 0);

      // Reset mid-frame, then a fresh frame
      applyStimulus(0, 4'd0, 1, 0);
      applyStimulus(1, 4'd1, 0, 0);
      applyStimulus(1, 4'd15, 0, 0);
      applyStimulus(1, 4'd1, 0, 0);
      applyStimulus(1, 4'd15, 0, 0);
      applyStimulus(1, 4'd1, 0, 0);
      #2 rst = 1'b1;
      #1;
      checkOutput("t6_rst_busy", busy, 0);
      checkOutput("t6_rst_in_ready", in_ready, 0);
      checkOutput("t6_rst_max", max_out, 0);
      checkOutput("t6_rst_min", min_out, 0);
      checkOutput("t6_rst_done", done, 0);
      #1 rst = 1'b0;
      applyStimulus(1, 4'd3, 0, 0);
      checkOutput("t6_post_in_ready", in_ready, 0);
      checkOutput("t6_post_busy", busy, 0);
      applyStimulus(0, 4'd0, 1, 0);
      for (int i = 0; i < 8; i++) applyStimulus(1, t6[i], 0, 0);
      checkOutput("t6_done", done, 1);
      checkOutput("t6_max", max_out, 8);
      checkOutput("t6_min", min_out, 2);
      checkRange("t6_range", 4'd6);
      applyStimulus(0, 4'd0, 0, 0);
      checkOutput("t6_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
